mix_columns_engine: RTL
=======================

Name: mix_columns_engine

Overview:
Parametrised AES MixColumns/InvMixColumns engine that replaces the purely combinational 128-bit mixer in the round datapath.
- Processes a 128-bit state over 4/COLS_PER_CYCLE clock cycles, so area can be traded against throughput.
- Supports forward and inverse mode, selected per block.
- Uses valid/ready handshakes on input and output so it sits between the ShiftRows stage and AddRoundKey in the iterative round core.

Parameters:
COLS_PER_CYCLE, 1, columns transformed per clock; legal values 1, 2, 4; any other value is an elaboration error.
N (localparam), 4/COLS_PER_CYCLE, processing cycles per block.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  in_data/in_inv valid
in_ready  output  1  engine accepts a block this cycle
in_data  input  128  state; column c = bits [127-32c -: 32]; first byte of a column is its MSB byte
in_inv  input  1  0 = MixColumns, 1 = InvMixColumns; sampled with in_data
out_valid  output  1  out_data holds a finished block
out_ready  input  1  downstream accepts out_data
out_data  output  128  transformed state, same byte/column ordering as in_data
busy  output  1  high in RUN state

Behaviour:
- Single clock; reset is synchronous and active-high.
- Reset (rst high at an edge): state=IDLE, col counter=0, out_valid=0, busy=0, out_data=0, working register=0. Reset mid-block discards the block; nothing is emitted.
- FSM states:
  - IDLE: in_ready=1. in_valid&in_ready latches in_data and in_inv, then goes to RUN with col=0.
  - RUN: busy=1, in_ready=0. Each edge replaces columns col .. col+COLS_PER_CYCLE-1 of the working register with their transform, then col += COLS_PER_CYCLE. After N RUN edges the state goes to DONE.
  - DONE: out_valid=1 and out_data = working register, held stable until out_ready. in_ready = out_ready in DONE.
    - out_ready & in_valid: the new block loads and the state goes directly to RUN (zero bubble).
    - out_ready & !in_valid: go to IDLE.
    - !out_ready: stay in DONE; out_data and out_valid are unchanged.
- Latency: if a block is accepted at edge E, out_valid is high from edge E+N. Sustained throughput is one block per N+1 cycles.
- in_data and in_inv changing while busy has no effect. Mode is latched per block.
- Column transform (GF(2^8), reduction polynomial 0x11B; xtime(b) = (b<<1) ^ (b[7] ? 0x1B : 0)), on input column bytes b0..b3:
  - Forward: r_i = 2·b_i ^ 3·b_(i+1) ^ b_(i+2) ^ b_(i+3), indices mod 4.
  - Inverse: r_i = 14·b_i ^ 11·b_(i+1) ^ 13·b_(i+2) ^ 9·b_(i+3).
  - Result is purely combinational within a cycle; the only storage is the working register.
- The col counter wraps to 0 on leaving RUN. col never exceeds 4-COLS_PER_CYCLE.
- out_valid is never asserted in IDLE or RUN, and never deasserts without out_ready or rst.

Test Plan:
- Forward full state, COLS_PER_CYCLE=1: in_data=0xdb135345_f20a225c_01010101_c6c6c6c6, inv=0 -> out_valid exactly 4 cycles after acceptance; out_data=0x8e4da1bc_9fdc589d_01010101_c6c6c6c6.
- Inverse, COLS_PER_CYCLE=2: in_data=0x8e4da1bc_9fdc589d_01010101_c6c6c6c6, inv=1 -> out_valid after 2 cycles; out_data=0xdb135345_f20a225c_01010101_c6c6c6c6.
- Round trip, COLS_PER_CYCLE=4, 1000 random states: forward then inverse returns the original state; latency is 1 cycle each.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 -> in_ready=0 and out_data stable. Then pulse out_ready together with in_valid -> next block accepted on the same edge and busy=1 on the next cycle.
- Reset mid-block: assert rst on the 2nd RUN cycle (COLS_PER_CYCLE=1) -> next cycle state IDLE, out_valid=0, out_data=0, in_ready=1, and no output for that block.
- Mode latching: accept with inv=0, toggle in_inv and in_data during RUN -> output equals the forward transform of the originally accepted data.

Source files
------------

// File: rtl/mix_columns_engine.sv
// AES MixColumns / InvMixColumns over a 128-bit state, COLS_PER_CYCLE columns per clock.
// Latency N = 4/COLS_PER_CYCLE cycles from acceptance; the result is held in DONE until out_ready.
module mix_columns_engine #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int N = 4 / COLS_PER_CYCLE;

  generate
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
      $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state, state_nxt;
  logic [1:0]   col;
  logic [127:0] work, work_nxt;
  logic         mode_inv;
  logic         load, last;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Inverse coefficients are built from x8/x4/x2 multiples: 9=8+1, 11=8+2+1, 13=8+4+1, 14=8+4+2.
  function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv);
    logic [7:0] b [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] r [4];
    for (int i = 0; i < 4; i++) begin
      b[i]  = c[31-8*i -: 8];
      x2[i] = xt(b[i]);
      x4[i] = xt(x2[i]);
      x8[i] = xt(x4[i]);
    end
    for (int i = 0; i < 4; i++) begin
      int j1, j2, j3;
      j1 = (i + 1) % 4;
      j2 = (i + 2) % 4;
      j3 = (i + 3) % 4;
      if (inv)
        r[i] = (x8[i] ^ x4[i] ^ x2[i]) ^ (x8[j1] ^ x2[j1] ^ b[j1]) ^
               (x8[j2] ^ x4[j2] ^ b[j2]) ^ (x8[j3] ^ b[j3]);
      else
        r[i] = x2[i] ^ x2[j1] ^ b[j1] ^ b[j2] ^ b[j3];
    end
    return {r[0], r[1], r[2], r[3]};
  endfunction

  always_comb begin
    work_nxt = work;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      int idx;
      idx = int'(col) + k;
      work_nxt[127-32*idx -: 32] = mix_col(work[127-32*idx -: 32], mode_inv);
    end
  end

  assign last      = (col == 2'((N - 1) * COLS_PER_CYCLE));
  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign load      = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN);
  assign out_data  = work;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = in_valid ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      col      <= '0;
      work     <= '0;
      mode_inv <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        work     <= in_data;
        mode_inv <= in_inv;
        col      <= '0;
      end else if (state == RUN) begin
        work <= work_nxt;
        col  <= last ? 2'd0 : col + 2'(COLS_PER_CYCLE);
      end
    end
  end

endmodule
